lsram_mem_arbiter: RTL and testbench
====================================

LSRAM_MEM_ARBITER -- requirements
Module: lsram_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_AWIDTH, default 9, meaning the SRAM word address width.
REQ-002 SHALL have parameter MEM_DEPTH, default 512, meaning the number of SRAM words (at most 2^MEM_AWIDTH).
REQ-003 SHALL have parameter RD_LATENCY, default 1, legal values 1..2, meaning the cycles from mem_ren to valid mem_rdata.
REQ-004 SHALL have port HCLK, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port HRESETN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports reqN_ren/reqN_wen (N=0,1), input, 1 bit each: read/write request, held until granted.
REQ-007 SHALL have ports reqN_addr (input, MEM_AWIDTH), reqN_byteen (input, 4) and reqN_wdata (input, 32): request qualifiers.
REQ-008 SHALL have ports reqN_gnt (output, 1), reqN_rvalid (output, 1) and reqN_rdata (output, 32): grant and read return.
REQ-009 SHALL have ports mem_ren/mem_wen (output, 1), mem_addr (output, MEM_AWIDTH), mem_byteen (output, 4) and mem_wdata (output, 32): SRAM port.
REQ-010 SHALL have port mem_rdata, input, 32 bits: SRAM read data.
REQ-011 SHALL have port init_done, output, 1 bit: high when requester traffic is accepted.

Function
REQ-012 SHALL form a request when reqN_ren|reqN_wen; if both are high, the request is a write.
REQ-013 SHALL grant at most one requester per cycle; reqN_gnt is combinational, in the same cycle as the request, while init_done=1.
REQ-014 SHALL drive mem_* combinationally from the granted requester; with no grant, mem_ren=mem_wen=0 and addr/byteen/wdata hold 0.
REQ-015 SHALL arbitrate round-robin: a single requester is granted immediately; on contention the requester not granted last wins.
REQ-016 SHALL update the last-granted pointer only on a grant.
REQ-017 SHALL guarantee that a held request is granted within 2 cycles; sustained throughput is 1 access per cycle.
REQ-018 SHALL track read ownership in a RD_LATENCY-deep register pipeline of {valid, id}.
REQ-019 SHALL assert reqN_rvalid for exactly 1 cycle, RD_LATENCY cycles after the read grant, with reqN_rdata=mem_rdata in that cycle; otherwise reqN_rdata=0.
REQ-020 SHALL give no response for writes.
REQ-021 SHALL support back-to-back reads, interleaved between requesters, with in-order returns.

Reset
REQ-022 SHALL on HRESETN low asynchronously clear: gnt, rvalid, rdata, mem_ren, mem_wen, the read pipeline and the pointer (req0 wins the first contention).
REQ-023 SHALL discard in-flight read returns when reset asserts mid-operation; no rvalid appears after reset release for pre-reset reads.

Configuration
REQ-024 SHALL implement macro LSRAM_ARB_MEMINIT_EN.
REQ-025 SHALL, when LSRAM_ARB_MEMINIT_EN is defined, use FSM states INIT and RUN:
- reset enters INIT with init_done=0.
- INIT writes 32'h0, byteen 4'hF, to addresses 0..MEM_DEPTH-1, one per cycle, from a counter.
- INIT issues no grants; requests stay pending.
- after the write to MEM_DEPTH-1, the next state is RUN with init_done=1.
- RUN is permanent until reset.
REQ-026 SHALL, when LSRAM_ARB_MEMINIT_EN is not defined, have no INIT state or counter and tie init_done to 1.

Structure
REQ-027 SHALL place requester-id encoding, FSM state encoding and RD_LATENCY legal range in shared package lsram_arb_pkg.
REQ-028 SHALL implement the read-return pipeline as sub-module lsram_arb_rdtrack.
REQ-029 SHALL have other logic flat; total RTL 120-400 lines.

Verification
REQ-030 Scenario: req0 read addr 0x010 alone, RD_LATENCY=1 -> req0_gnt same cycle; req0_rvalid next cycle with mem_rdata; req1_rvalid=0.
REQ-031 Scenario: req0 and req1 write held together from reset -> grants req0, req1, req0, req1 on consecutive cycles; mem_addr follows.
REQ-032 Scenario: alternating reads req1 0x1FF, req0 0x000, RD_LATENCY=2 -> rvalid pulses 2 cycles after each grant, to the correct owner, in order.
REQ-033 Scenario: ren=wen=1, byteen 4'b0011 -> mem_wen=1, mem_ren=0, mem_byteen=4'b0011; no rvalid.
REQ-034 Scenario: reset asserted 0 cycles after a read grant -> all outputs 0 immediately; no rvalid after release.
REQ-035 Scenario: LSRAM_ARB_MEMINIT_EN defined, MEM_DEPTH=16 -> 16 zero writes to 0..15; req0 held meanwhile is granted in the cycle init_done first reads 1.

Source files
------------

// File: rtl/lsram_arb_pkg.sv
// lsram_arb_pkg: shared requester ids, init FSM states and read-latency range for lsram_mem_arbiter
package lsram_arb_pkg;
  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_t;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} arb_state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  function automatic bit rd_lat_ok(input int lat);
    return lat >= RD_LAT_MIN && lat <= RD_LAT_MAX;
  endfunction
endpackage

// File: rtl/lsram_arb_rdtrack.sv
// lsram_arb_rdtrack: RD_LATENCY-deep {valid,id} pipeline tracking read ownership; ports HCLK/HRESETN, push/push_id in, pop/pop_id out
module lsram_arb_rdtrack
  import lsram_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    HCLK,
  input  logic    HRESETN,
  input  logic    push,
  input  req_id_t push_id,
  output logic    pop,
  output req_id_t pop_id
);
  logic [RD_LATENCY-1:0] vld;
  req_id_t               id [RD_LATENCY];
  always_ff @(posedge HCLK or negedge HRESETN)
    if (!HRESETN) begin
      vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) id[i] <= REQ0;
    end else begin
      vld[0] <= push;
      id[0]  <= push_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        id[i]  <= id[i-1];
      end
    end
  assign pop    = vld[RD_LATENCY-1];
  assign pop_id = id[RD_LATENCY-1];
endmodule

// File: rtl/lsram_mem_arbiter.sv
// lsram_mem_arbiter: 2-requester round-robin SRAM arbiter with read return routing; req0/req1 ren/wen/addr/byteen/wdata in, gnt/rvalid/rdata out, mem_* SRAM port, init_done; optional zero-fill on LSRAM_ARB_MEMINIT_EN
module lsram_mem_arbiter
  import lsram_arb_pkg::*;
#(
  parameter int MEM_AWIDTH = 9,
  parameter int MEM_DEPTH  = 512,
  parameter int RD_LATENCY = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  req0_ren,
  input  logic                  req0_wen,
  input  logic [MEM_AWIDTH-1:0] req0_addr,
  input  logic [3:0]            req0_byteen,
  input  logic [31:0]           req0_wdata,
  output logic                  req0_gnt,
  output logic                  req0_rvalid,
  output logic [31:0]           req0_rdata,
  input  logic                  req1_ren,
  input  logic                  req1_wen,
  input  logic [MEM_AWIDTH-1:0] req1_addr,
  input  logic [3:0]            req1_byteen,
  input  logic [31:0]           req1_wdata,
  output logic                  req1_gnt,
  output logic                  req1_rvalid,
  output logic [31:0]           req1_rdata,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  output logic [3:0]            mem_byteen,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  init_done
);
  logic                  req0, req1, run, init_wr, rv;
  logic [MEM_AWIDTH-1:0] init_addr;
  req_id_t               last, rv_id;
  if (!rd_lat_ok(RD_LATENCY)) begin : g_bad_lat
    $error("RD_LATENCY out of range");
  end
  if (MEM_DEPTH > (1 << MEM_AWIDTH)) begin : g_bad_depth
    $error("MEM_DEPTH exceeds address space");
  end
`ifdef LSRAM_ARB_MEMINIT_EN
  arb_state_t            state, state_nxt;
  logic [MEM_AWIDTH-1:0] cnt, cnt_nxt;
  always_ff @(posedge HCLK or negedge HRESETN)
    if (!HRESETN) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  always_comb begin
    state_nxt = (state == INIT && cnt == MEM_AWIDTH'(MEM_DEPTH - 1)) ? RUN : state;
    cnt_nxt   = (state == INIT) ? cnt + 1'b1 : cnt;
  end
  assign init_done = state == RUN;
  assign init_wr   = HRESETN && state == INIT;
  assign init_addr = cnt;
`else
  assign init_done = 1'b1;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif
  assign req0 = req0_ren | req0_wen;
  assign req1 = req1_ren | req1_wen;
  // gating with HRESETN makes grants and the SRAM strobes drop the moment reset asserts
  assign run      = HRESETN & init_done;
  assign req0_gnt = run & req0 & (~req1 | last == REQ1);
  assign req1_gnt = run & req1 & ~req0_gnt;
  // a granted request with wen low must be a read, since ren|wen formed it
  assign mem_wen    = init_wr | (req0_gnt & req0_wen) | (req1_gnt & req1_wen);
  assign mem_ren    = (req0_gnt & ~req0_wen) | (req1_gnt & ~req1_wen);
  assign mem_addr   = req0_gnt ? req0_addr : req1_gnt ? req1_addr : init_addr;
  assign mem_byteen = req0_gnt ? req0_byteen : req1_gnt ? req1_byteen : init_wr ? 4'hF : 4'h0;
  assign mem_wdata  = req0_gnt ? req0_wdata : req1_gnt ? req1_wdata : 32'h0;
  // reset value REQ1 lets req0 win the first contention
  always_ff @(posedge HCLK or negedge HRESETN)
    if (!HRESETN) last <= REQ1;
    else if (req0_gnt) last <= REQ0;
    else if (req1_gnt) last <= REQ1;
  lsram_arb_rdtrack #(.RD_LATENCY(RD_LATENCY)) u_rdtrack (
    .HCLK   (HCLK),
    .HRESETN(HRESETN),
    .push   (mem_ren),
    .push_id(req1_gnt ? REQ1 : REQ0),
    .pop    (rv),
    .pop_id (rv_id)
  );
  assign req0_rvalid = rv & rv_id == REQ0;
  assign req1_rvalid = rv & rv_id == REQ1;
  assign req0_rdata  = req0_rvalid ? mem_rdata : 32'h0;
  assign req1_rdata  = req1_rvalid ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_lsram_mem_arbiter.sv
// tb_lsram_mem_arbiter: scoreboard bench for lsram_mem_arbiter at RD_LATENCY 1 (a) and 2 (b) on shared stimulus
module tb_lsram_mem_arbiter;
  localparam int DEPTH = 16;
`ifdef LSRAM_ARB_MEMINIT_EN
  localparam int INIT_N = DEPTH;
`else
  localparam int INIT_N = 0;
`endif
  typedef struct {
    logic id;
    int   due;
  } exp_t;
  logic        HCLK, HRESETN;
  logic        req0_ren, req0_wen, req1_ren, req1_wen;
  logic [8:0]  req0_addr, req1_addr;
  logic [3:0]  req0_byteen, req1_byteen;
  logic [31:0] req0_wdata, req1_wdata, mem_rdata;
  logic        gnt0_a, gnt1_a, rv0_a, rv1_a, ren_a, wen_a, done_a;
  logic        gnt0_b, gnt1_b, rv0_b, rv1_b, ren_b, wen_b, done_b;
  logic [31:0] rd0_a, rd1_a, wd_a, rd0_b, rd1_b, wd_b;
  logic [8:0]  addr_a, addr_b;
  logic [3:0]  be_a, be_b;
  logic [1:0]  rv0, rv1;
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  exp_t        sb [2][$];
  exp_t        e;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        m_last;
  lsram_mem_arbiter #(.MEM_AWIDTH(9), .MEM_DEPTH(DEPTH), .RD_LATENCY(1)) u_dut_a (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .req0_ren(req0_ren), .req0_wen(req0_wen), .req0_addr(req0_addr), .req0_byteen(req0_byteen),
    .req0_wdata(req0_wdata), .req0_gnt(gnt0_a), .req0_rvalid(rv0_a), .req0_rdata(rd0_a),
    .req1_ren(req1_ren), .req1_wen(req1_wen), .req1_addr(req1_addr), .req1_byteen(req1_byteen),
    .req1_wdata(req1_wdata), .req1_gnt(gnt1_a), .req1_rvalid(rv1_a), .req1_rdata(rd1_a),
    .mem_ren(ren_a), .mem_wen(wen_a), .mem_addr(addr_a), .mem_byteen(be_a), .mem_wdata(wd_a),
    .mem_rdata(mem_rdata), .init_done(done_a)
  );
  lsram_mem_arbiter #(.MEM_AWIDTH(9), .MEM_DEPTH(DEPTH), .RD_LATENCY(2)) u_dut_b (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .req0_ren(req0_ren), .req0_wen(req0_wen), .req0_addr(req0_addr), .req0_byteen(req0_byteen),
    .req0_wdata(req0_wdata), .req0_gnt(gnt0_b), .req0_rvalid(rv0_b), .req0_rdata(rd0_b),
    .req1_ren(req1_ren), .req1_wen(req1_wen), .req1_addr(req1_addr), .req1_byteen(req1_byteen),
    .req1_wdata(req1_wdata), .req1_gnt(gnt1_b), .req1_rvalid(rv1_b), .req1_rdata(rd1_b),
    .mem_ren(ren_b), .mem_wen(wen_b), .mem_addr(addr_b), .mem_byteen(be_b), .mem_wdata(wd_b),
    .mem_rdata(mem_rdata), .init_done(done_b)
  );
  assign rv0 = {rv0_b, rv0_a};
  assign rv1 = {rv1_b, rv1_a};
  assign rd0[0] = rd0_a;
  assign rd0[1] = rd0_b;
  assign rd1[0] = rd1_a;
  assign rd1[1] = rd1_b;
  assign mem_rdata = {16'hD00D, cyc[15:0]};
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge HCLK) begin
    if (HRESETN) for (int d = 0; d < 2; d++) begin
      if (sb[d].size() != 0 && sb[d][0].due < cyc) begin
        check($sformatf("rv_missing%0d", d), 0, 1);
        void'(sb[d].pop_front());
      end
      if (rv0[d] | rv1[d]) begin
        if (sb[d].size() == 0) check($sformatf("rv_spurious%0d", d), 1, 0);
        else begin
          e = sb[d].pop_front();
          check($sformatf("rv_owner%0d", d), {30'h0, rv1[d], rv0[d]}, e.id ? 2'b10 : 2'b01);
          check($sformatf("rv_cycle%0d", d), cyc, e.due);
          check($sformatf("rv_data%0d", d), e.id ? rd1[d] : rd0[d], {16'hD00D, e.due[15:0]});
        end
      end
      if (!rv0[d]) check($sformatf("rd0_idle%0d", d), rd0[d], 0);
      if (!rv1[d]) check($sformatf("rd1_idle%0d", d), rd1[d], 0);
    end
  end
  task automatic push_rd(input logic id);
    sb[0].push_back('{id: id, due: cyc + 1});
    sb[1].push_back('{id: id, due: cyc + 2});
  endtask
  task automatic drive(input logic r0r, input logic r0w, input logic [8:0] a0, input logic [3:0] b0,
                       input logic r1r, input logic r1w, input logic [8:0] a1, input logic [3:0] b1);
    logic g0, g1, w, rd;
    @(posedge HCLK);
    #1;
    req0_ren = r0r; req0_wen = r0w; req0_addr = a0; req0_byteen = b0; req0_wdata = 32'h1000_0000 | a0;
    req1_ren = r1r; req1_wen = r1w; req1_addr = a1; req1_byteen = b1; req1_wdata = 32'h2000_0000 | a1;
    g0 = (r0r | r0w) && (!(r1r | r1w) || m_last);
    g1 = (r1r | r1w) && !g0;
    w  = g0 ? r0w : g1 ? r1w : 1'b0;
    rd = (g0 | g1) && !w;
    @(negedge HCLK);
    check("gnt0", gnt0_a, g0);
    check("gnt1", gnt1_a, g1);
    check("gnt_b", {gnt1_b, gnt0_b}, {g1, g0});
    check("mem_wen", wen_a, w);
    check("mem_ren", ren_a, rd);
    check("mem_ren_b", ren_b, rd);
    check("mem_addr", addr_a, g0 ? a0 : g1 ? a1 : 9'h0);
    check("mem_byteen", be_a, g0 ? b0 : g1 ? b1 : 4'h0);
    check("mem_wdata", wd_a, g0 ? 32'h1000_0000 | a0 : g1 ? 32'h2000_0000 | a1 : 32'h0);
    if (rd) push_rd(g1);
    if (g0 | g1) m_last = g1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 9'h0, 4'h0, 0, 0, 9'h0, 4'h0);
  endtask
  initial begin
    int k;
    HRESETN = 1'b0;
    {req0_ren, req0_wen, req1_ren, req1_wen} = '0;
    req0_addr = '0; req1_addr = '0; req0_byteen = '0; req1_byteen = '0;
    req0_wdata = '0; req1_wdata = '0;
    m_last = 1'b1;
    repeat (3) @(posedge HCLK);
    req0_ren = 1'b1; req0_addr = 9'h010; req0_byteen = 4'hF;
    #1;
    check("rst_gnt", {gnt1_a, gnt0_a, gnt1_b, gnt0_b}, 0);
    check("rst_mem", {ren_a, wen_a, ren_b, wen_b}, 0);
    check("rst_rv", {rv1, rv0}, 0);
    check("rst_done", done_a, INIT_N == 0);
    @(posedge HCLK);
    #1;
    HRESETN = 1'b1;
    k = 0;
    @(negedge HCLK);
    while (!done_a && k < 100) begin
      check("init_wen", wen_a, 1);
      check("init_addr", addr_a, k);
      check("init_wdata", wd_a, 0);
      check("init_be", be_a, 4'hF);
      check("init_gnt", gnt0_a, 0);
      k++;
      @(negedge HCLK);
    end
    check("init_cnt", k, INIT_N);
    check("first_gnt0", gnt0_a, 1);
    check("first_ren", ren_a, 1);
    check("first_addr", addr_a, 9'h010);
    push_rd(1'b0);
    m_last = 1'b0;
    idle(3);
    drive(0, 0, 9'h0, 4'h0, 1, 1, 9'h055, 4'b0011);
    idle(2);
    drive(0, 0, 9'h0, 4'h0, 1, 0, 9'h1FF, 4'hF);
    drive(1, 0, 9'h000, 4'hF, 0, 0, 9'h0, 4'h0);
    drive(0, 0, 9'h0, 4'h0, 1, 0, 9'h1FF, 4'hF);
    drive(1, 0, 9'h000, 4'hF, 0, 0, 9'h0, 4'h0);
    for (int i = 0; i < 4; i++) drive(1, 0, 9'h020 + 9'(i), 4'hF, 1, 0, 9'h120 + 9'(i), 4'hF);
    idle(3);
    drive(1, 0, 9'h033, 4'hF, 0, 0, 9'h0, 4'h0);
    @(posedge HCLK);
    #1;
    check("pre_rst_rv_a", rv0_a, 1);
    HRESETN = 1'b0;
    sb[0].delete();
    sb[1].delete();
    #1;
    check("mid_rst_gnt", {gnt1_a, gnt0_a, gnt1_b, gnt0_b}, 0);
    check("mid_rst_mem", {ren_a, wen_a, ren_b, wen_b}, 0);
    check("mid_rst_rv", {rv1, rv0}, 0);
    check("mid_rst_rd", rd0_a | rd0_b, 0);
    req0_ren = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETN = 1'b1;
    m_last = 1'b1;
    k = 0;
    @(negedge HCLK);
    while (!done_a && k < 100) begin
      k++;
      @(negedge HCLK);
    end
    check("reinit_cnt", k, INIT_N);
    for (int i = 0; i < 4; i++) drive(0, 1, 9'h040 + 9'(i), 4'hF, 0, 1, 9'h140 + 9'(i), 4'h3);
    drive(1, 0, 9'h0AA, 4'hF, 1, 1, 9'h0BB, 4'hC);
    drive(1, 0, 9'h0AA, 4'hF, 0, 0, 9'h0, 4'h0);
    idle(4);
    check("sb_empty_a", sb[0].size(), 0);
    check("sb_empty_b", sb[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
